// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC multiplexed-bus engine: FSM states, strobe
// patterns and the chip's register map.
package rtc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        GAP1,
        DATA,
        GAP2,
        DONE
    } state_t;

    // Strobe patterns, packed as {CS, RD, WR, AD}, all active-low.
    localparam logic [3:0] STROBE_IDLE  = 4'b1111;
    localparam logic [3:0] STROBE_ADDR  = 4'b0100;
    localparam logic [3:0] STROBE_WRITE = 4'b0101;
    localparam logic [3:0] STROBE_READ  = 4'b0011;

    localparam logic [7:0] ADDR_SEG  = 8'h21;
    localparam logic [7:0] ADDR_MIN  = 8'h22;
    localparam logic [7:0] ADDR_HOR  = 8'h23;
    localparam logic [7:0] ADDR_DIA  = 8'h24;
    localparam logic [7:0] ADDR_MES  = 8'h25;
    localparam logic [7:0] ADDR_ANO  = 8'h26;
    localparam logic [7:0] ADDR_TSEG = 8'h31;
    localparam logic [7:0] ADDR_TMIN = 8'h32;
    localparam logic [7:0] ADDR_THOR = 8'h33;

    // Phase counter preload: a phase of n cycles counts n-1 down to 0.
    function automatic logic [7:0] phase_load(input int unsigned cycles);
        return 8'(cycles - 1);
    endfunction

endpackage

// File: rtl/rtc_bus_ctrl.sv
// Bus-cycle engine for the external RTC: one request becomes an address phase
// plus a data phase on the multiplexed DatAdd bus, with registered strobes.
module rtc_bus_ctrl
    import rtc_pkg::*;
#(
    parameter int unsigned PULSE_CYC = 8,
    parameter int unsigned GAP_CYC   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       CS,
    output logic       RD,
    output logic       WR,
    output logic       AD,
    inout  logic [7:0] DatAdd
);

    localparam logic [7:0] PULSE_LOAD = phase_load(PULSE_CYC);
    localparam logic [7:0] GAP_LOAD   = phase_load(GAP_CYC);

    state_t     state;
    logic [7:0] cnt;
    logic       we_q;
    logic [7:0] wdata_q;
    logic [7:0] bus_out;
    logic       bus_oe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            we_q            <= 1'b0;
            wdata_q         <= '0;
            bus_out         <= '0;
            bus_oe          <= 1'b0;
            {CS, RD, WR, AD} <= STROBE_IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            rdata           <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        we_q             <= we;
                        wdata_q          <= wdata;
                        bus_out          <= addr;
                        bus_oe           <= 1'b1;
                        {CS, RD, WR, AD} <= STROBE_ADDR;
                        cnt              <= PULSE_LOAD;
                        busy             <= 1'b1;
                        state            <= ADDR;
                    end
                end
                ADDR: begin
                    if (cnt == '0) begin
                        {CS, RD, WR, AD} <= STROBE_IDLE;
                        cnt              <= GAP_LOAD;
                        state            <= GAP1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                GAP1: begin
                    // Address stays on the bus for the first gap cycle only.
                    bus_oe <= 1'b0;
                    if (cnt == '0) begin
                        cnt   <= PULSE_LOAD;
                        state <= DATA;
                        if (we_q) begin
                            {CS, RD, WR, AD} <= STROBE_WRITE;
                            bus_out          <= wdata_q;
                            bus_oe           <= 1'b1;
                        end else begin
                            {CS, RD, WR, AD} <= STROBE_READ;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        if (!we_q) begin
                            rdata <= DatAdd;
                        end
                        {CS, RD, WR, AD} <= STROBE_IDLE;
                        cnt              <= GAP_LOAD;
                        state            <= GAP2;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                GAP2: begin
                    bus_oe <= 1'b0;
                    if (cnt == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign DatAdd = bus_oe ? bus_out : 'z;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Self-checking bench for rtc_bus_ctrl: chip models on the DatAdd buses, a
// vector table with a done/rdata scoreboard, and hand-written corner sequences.
module tb_rtc_bus_ctrl;
    import rtc_pkg::*;

    localparam int unsigned P = 8;
    localparam int unsigned G = 4;
    localparam int LAT_A = int'(2 * P + 2 * G);

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp_rd;
        logic [7:0] exp_mem;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [7:0] rd;
    } sb_t;

    logic clk = 1'b0;
    logic reset;
    logic preload;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       start_a, we_a, busy_a, done_a, cs_a, rd_a, wr_a, ad_a;
    logic [7:0] addr_a, wdata_a, rdata_a;
    wire  [7:0] bus_a;
    logic       start_b, we_b, busy_b, done_b, cs_b, rd_b, wr_b, ad_b;
    logic [7:0] addr_b, wdata_b, rdata_b;
    wire  [7:0] bus_b;

    rtc_bus_ctrl #(.PULSE_CYC(P), .GAP_CYC(G)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .we(we_a), .addr(addr_a),
        .wdata(wdata_a), .rdata(rdata_a), .busy(busy_a), .done(done_a),
        .CS(cs_a), .RD(rd_a), .WR(wr_a), .AD(ad_a), .DatAdd(bus_a)
    );

    rtc_bus_ctrl #(.PULSE_CYC(1), .GAP_CYC(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .we(we_b), .addr(addr_b),
        .wdata(wdata_b), .rdata(rdata_b), .busy(busy_b), .done(done_b),
        .CS(cs_b), .RD(rd_b), .WR(wr_b), .AD(ad_b), .DatAdd(bus_b)
    );

    // Chip models: address latch, read drive, write committed when WR releases
    // (an abort by reset never commits).
    logic [7:0] mem_a [256];
    logic [7:0] lat_a, pend_a;
    logic       pend_v_a;
    logic [7:0] mem_b [256];
    logic [7:0] lat_b;

    assign bus_a = (!cs_a && wr_a && !rd_a && ad_a) ? mem_a[lat_a] : 8'hzz;
    assign bus_b = (!cs_b && wr_b && !rd_b && ad_b) ? mem_b[lat_b] : 8'hzz;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= 8'h00;
            mem_a[ADDR_MIN] <= 8'h37;
            mem_a[ADDR_HOR] <= 8'h10;
            mem_a[ADDR_SEG] <= 8'h5A;
            mem_a[ADDR_MES] <= 8'h11;
            pend_v_a        <= 1'b0;
            lat_a           <= 8'h00;
            pend_a          <= 8'h00;
        end else if (reset) begin
            pend_v_a <= 1'b0;
        end else if (!cs_a && !wr_a && !ad_a && rd_a) begin
            lat_a <= bus_a;
        end else if (!cs_a && !wr_a && rd_a && ad_a) begin
            pend_a   <= bus_a;
            pend_v_a <= 1'b1;
        end else if (pend_v_a) begin
            mem_a[lat_a] <= pend_a;
            pend_v_a     <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= 8'h00;
            mem_b[ADDR_TSEG] <= 8'hA5;
            lat_b            <= 8'h00;
        end else if (!reset && !cs_b && !wr_b && !ad_b && rd_b) begin
            lat_b <= bus_b;
        end
    end

    int   n_checks = 0;
    int   n_pass = 0;
    int   done_cnt = 0;
    sb_t  sb[$];
    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] er, output int sc);
        we_a = w; addr_a = a; wdata_a = d; start_a = 1'b1;
        @(posedge clk);
        #1;
        sc = cyc;
        sb.push_back('{cyc: sc + LAT_A, rd: er});
        @(negedge clk);
        start_a = 1'b0;
        check("busy_after_start", int'(busy_a), 1);
    endtask

    task automatic wait_done();
        for (int n = 0; n < 300 && (sb.size() != 0 || busy_a); n++) @(negedge clk);
        if (sb.size() != 0 || busy_a) begin
            check("transaction_timeout", 1, 0);
            sb.delete();
        end
    endtask

    initial begin
        int sc;
        int dc0;
        int dcyc;

        vecs[0] = '{1'b0, ADDR_MIN,  8'hC8, 8'h37, 8'h37};
        vecs[1] = '{1'b0, ADDR_DIA,  8'hFF, 8'h00, 8'h00};
        vecs[2] = '{1'b1, ADDR_HOR,  8'h59, 8'h00, 8'h59};
        vecs[3] = '{1'b0, ADDR_HOR,  8'h00, 8'h59, 8'h59};
        vecs[4] = '{1'b1, ADDR_SEG,  8'hA3, 8'h59, 8'hA3};
        vecs[5] = '{1'b0, ADDR_SEG,  8'h00, 8'hA3, 8'hA3};
        vecs[6] = '{1'b1, ADDR_THOR, 8'h3C, 8'hA3, 8'h3C};
        vecs[7] = '{1'b0, ADDR_THOR, 8'h00, 8'h3C, 8'h3C};

        reset = 1'b1; preload = 1'b1;
        start_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        start_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
        repeat (3) @(negedge clk);
        check("reset_strobes_a", int'({cs_a, rd_a, wr_a, ad_a}), 'hF);
        check("reset_busy_a", int'(busy_a), 0);
        check("reset_done_a", int'(done_a), 0);
        check("reset_rdata_a", int'(rdata_a), 0);
        check("reset_strobes_b", int'({cs_b, rd_b, wr_b, ad_b}), 'hF);
        check("reset_rdata_b", int'(rdata_b), 0);
        preload = 1'b0; reset = 1'b0;
        @(negedge clk);

        fork
            begin : monitor
                logic [3:0] p;
                logic [3:0] prev_p = 4'hF;
                int idle_run = 0;
                bit had_txn = 0;
                sb_t e;
                forever begin
                    @(negedge clk);
                    if (!reset) begin
                        p = {cs_a, rd_a, wr_a, ad_a};
                        if (done_a) begin
                            done_cnt++;
                            if (sb.size() == 0) begin
                                check("unexpected_done", 1, 0);
                            end else begin
                                e = sb.pop_front();
                                check("done_cycle", cyc, e.cyc);
                                check("rdata_at_done", int'(rdata_a), int'(e.rd));
                                check("busy_at_done", int'(busy_a), 1);
                            end
                        end
                        if (!rd_a) check("bus_while_rd_low", int'(bus_a), int'(mem_a[lat_a]));
                        if (p != prev_p)
                            check("strobe_pattern", int'(p inside {4'hF, 4'h4, 4'h5, 4'h3}), 1);
                        if (p == 4'hF) begin
                            idle_run++;
                        end else begin
                            if (p == 4'h4 && prev_p == 4'hF && had_txn)
                                check("inter_txn_idle_gap", int'(idle_run >= int'(G + 2)), 1);
                            if (p == 4'h4) had_txn = 1;
                            idle_run = 0;
                        end
                        prev_p = p;
                    end
                end
            end
        join_none

        // Table-driven reads and writes.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_rd, sc);
            wait_done();
            check("chip_register", int'(mem_a[vecs[i].a]), int'(vecs[i].exp_mem));
        end

        // A second start while busy must be dropped, not queued.
        dc0 = done_cnt;
        drive(1'b0, ADDR_MIN, 8'h00, 8'h37, sc);
        @(negedge clk);
        we_a = 1'b1; addr_a = ADDR_DIA; wdata_a = 8'hEE; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);
        check("busy_reject_done_count", done_cnt - dc0, 1);
        check("busy_reject_no_write", int'(mem_a[ADDR_DIA]), 'h00);
        check("busy_reject_rdata", int'(rdata_a), 'h37);

        // Reset in the middle of a write's data phase.
        dc0 = done_cnt;
        drive(1'b1, ADDR_MES, 8'h77, 8'h37, sc);
        while (cyc < sc + 14) @(negedge clk);
        check("in_write_data_phase", int'({cs_a, rd_a, wr_a, ad_a}), 'h5);
        #2 reset = 1'b1;
        #1;
        check("abort_strobes", int'({cs_a, rd_a, wr_a, ad_a}), 'hF);
        check("abort_busy", int'(busy_a), 0);
        check("abort_done", int'(done_a), 0);
        check("abort_rdata", int'(rdata_a), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_done", done_cnt - dc0, 0);
        check("abort_register_kept", int'(mem_a[ADDR_MES]), 'h11);

        // Minimum phase lengths on the second instance.
        we_b = 1'b0; addr_b = ADDR_TSEG; wdata_b = 8'h00; start_b = 1'b1;
        @(posedge clk);
        #1;
        sc = cyc;
        @(negedge clk);
        start_b = 1'b0;
        dcyc = -1;
        for (int n = 0; n < 20 && dcyc < 0; n++) begin
            if (done_b) dcyc = cyc;
            else @(negedge clk);
        end
        check("min_timing_done_cycle", dcyc, sc + 4);
        check("min_timing_rdata", int'(rdata_b), 'hA5);

        // Start held high: a new transaction every 2P+2G+2 cycles.
        dc0 = done_cnt;
        we_a = 1'b0; addr_a = ADDR_SEG; wdata_a = 8'h00; start_a = 1'b1;
        @(posedge clk);
        #1;
        sc = cyc;
        for (int i = 0; i < 3; i++) sb.push_back('{cyc: sc + LAT_A + i * (LAT_A + 2), rd: 8'hA3});
        while (cyc < sc + 2 * (LAT_A + 2)) @(negedge clk);
        start_a = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);
        check("back_to_back_done_count", done_cnt - dc0, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
